// File: rtl/keypad_scanner.sv
// 4x3 membrane keypad scanner with whole-scan debounce.
// Presents the accepted key as a one-hot digit bus plus active-low start/stop.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [9:0] keyboard,
    output logic       startn,
    output logic       stopn,
    output logic       key_strobe
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    logic [DW-1:0] dwell_reg, dwell_next;
    logic [1:0]    col_reg, col_next;
    logic [7:0]    snap_reg, snap_next;
    logic [3:0]    pending_reg, pending_next;
    logic [CW-1:0] count_reg, count_next;
    logic [3:0]    stable_reg, stable_next;
    logic [9:0]    keyboard_reg, keyboard_next;
    logic          startn_reg, startn_next;
    logic          stopn_reg, stopn_next;
    logic          strobe_reg, strobe_next;

    logic          sample, scan_done;
    logic [11:0]   scan_bits;
    logic [3:0]    hits, hit_code, candidate;
    logic [3:0]    code_tab [12];

    // Key code for snapshot bit column*4+row.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_code
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int CODE = (ROW < 3) ? (ROW * 3 + COL + 1) :
                                  (COL == 0) ? 10 : (COL == 1) ? 0 : 11;
            assign code_tab[gi] = 4'(CODE);
        end
    endgenerate

    // Column 2 is consumed live on the completing edge, so only columns 0/1 are stored.
    assign sample    = (dwell_reg == DW'(SCAN_DIV - 1));
    assign scan_done = sample && (col_reg == 2'd2);
    assign scan_bits = {~row_n, snap_reg};

    always_comb begin
        hits     = 4'd0;
        hit_code = KEY_NONE;
        for (int i = 0; i < 12; i++) begin
            if (scan_bits[i]) begin
                hits     = hits + 4'd1;
                hit_code = code_tab[i];
            end
        end
        candidate = (hits == 4'd1) ? hit_code : KEY_NONE;
    end

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dwell_reg    <= '0;
            col_reg      <= '0;
            snap_reg     <= '0;
            pending_reg  <= KEY_NONE;
            count_reg    <= '0;
            stable_reg   <= KEY_NONE;
            keyboard_reg <= '0;
            startn_reg   <= 1'b1;
            stopn_reg    <= 1'b1;
            strobe_reg   <= 1'b0;
        end else begin
            dwell_reg    <= dwell_next;
            col_reg      <= col_next;
            snap_reg     <= snap_next;
            pending_reg  <= pending_next;
            count_reg    <= count_next;
            stable_reg   <= stable_next;
            keyboard_reg <= keyboard_next;
            startn_reg   <= startn_next;
            stopn_reg    <= stopn_next;
            strobe_reg   <= strobe_next;
        end
    end

    // Next-state logic
    always_comb begin
        dwell_next   = dwell_reg + DW'(1);
        col_next     = col_reg;
        snap_next    = snap_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        stable_next  = stable_reg;
        strobe_next  = 1'b0;

        if (sample) begin
            dwell_next = '0;
            col_next   = (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;
            if (col_reg != 2'd2)
                snap_next[{col_reg[0], 2'b00} +: 4] = ~row_n;
        end

        if (scan_done) begin
            if (candidate == pending_reg) begin
                if (count_reg != CW'(DEBOUNCE_SCANS))
                    count_next = count_reg + CW'(1);
            end else begin
                pending_next = candidate;
                count_next   = CW'(1);
            end
            if (count_next == CW'(DEBOUNCE_SCANS) && pending_next != stable_reg) begin
                stable_next = pending_next;
                strobe_next = (pending_next != KEY_NONE);
            end
        end

        // Outputs load with the new stable value so they change on the accepting edge.
        keyboard_next = '0;
        if (stable_next <= 4'd9)
            keyboard_next = 10'd1 << stable_next;
        startn_next = (stable_next != KEY_STAR);
        stopn_next  = (stable_next != KEY_HASH);
    end

    // Outputs
    always_comb begin
        case (col_reg)
            2'd0:    col_n = 3'b110;
            2'd1:    col_n = 3'b101;
            default: col_n = 3'b011;
        endcase
        keyboard   = keyboard_reg;
        startn     = startn_reg;
        stopn      = stopn_reg;
        key_strobe = strobe_reg;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
// Pressed-key bit index is column*4 + row.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [9:0] keyboard;
    logic       startn, stopn, key_strobe;

    logic [11:0] pressed = '0;
    int checks = 0;
    int errors = 0;
    int edge_num = -1;
    int strobe_cnt = 0;

    localparam logic [11:0] K1 = 12'h001, K7 = 12'h004, KSTAR = 12'h008, K5 = 12'h020,
                            K0 = 12'h080, K9 = 12'h400, KHASH = 12'h800;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .clear(clear), .row_n(row_n), .col_n(col_n),
        .keyboard(keyboard), .startn(startn), .stopn(stopn), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to the column currently driven low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
    end

    always @(negedge clk) if (key_strobe) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_num);
        end else
            $display("ok   %s: %0h (edge %0d)", tag, obs, edge_num);
    endtask

    task automatic do_reset(input logic [11:0] keys);
        clear   = 1'b1;
        pressed = keys;
        repeat (2) @(negedge clk);
        clear      = 1'b0;
        edge_num   = -1;
        strobe_cnt = 0;
    endtask

    task automatic step_to(input int n);
        while (edge_num < n) begin
            @(posedge clk);
            edge_num++;
        end
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [9:0] kb, input logic sn, input logic pn);
        check({tag, ".keyboard"}, 32'(keyboard), 32'(kb));
        check({tag, ".startn"}, 32'(startn), 32'(sn));
        check({tag, ".stopn"}, 32'(stopn), 32'(pn));
    endtask

    initial begin
        // Reset state and column rotation
        repeat (2) @(negedge clk);
        check("rst.col_n", 32'(col_n), 32'b110);
        check_outs("rst", 10'd0, 1'b1, 1'b1);
        check("rst.strobe", 32'(key_strobe), 32'd0);
        do_reset('0);
        step_to(2);  check("col@2", 32'(col_n), 32'b110);
        step_to(3);  check("col@3", 32'(col_n), 32'b101);
        step_to(7);  check("col@7", 32'(col_n), 32'b011);
        step_to(11); check("col@11", 32'(col_n), 32'b110);
        step_to(15); check("col@15", 32'(col_n), 32'b101);

        // Hold 5, release at edge 40
        do_reset(K5);
        step_to(34); check("k5.kb@34", 32'(keyboard), 32'd0);
        step_to(35); check("k5.kb@35", 32'(keyboard), 32'b0000100000);
        check("k5.strobe@35", 32'(key_strobe), 32'd1);
        step_to(36); check("k5.strobe@36", 32'(key_strobe), 32'd0);
        check("k5.strobes", 32'(strobe_cnt), 32'd1);
        step_to(40); pressed = '0;
        step_to(70); check("k5.kb@70", 32'(keyboard), 32'b0000100000);
        step_to(71); check_outs("k5rel@71", 10'd0, 1'b1, 1'b1);
        step_to(72); check("k5rel.strobes", 32'(strobe_cnt), 32'd1);

        // Star and hash
        do_reset(KSTAR);
        step_to(34); check("star.startn@34", 32'(startn), 32'd1);
        step_to(35); check_outs("star@35", 10'd0, 1'b0, 1'b1);
        do_reset(KHASH);
        step_to(35); check_outs("hash@35", 10'd0, 1'b1, 1'b0);
        check("hash.strobe@35", 32'(key_strobe), 32'd1);

        // Hold 0 two scans, drop across the column-1 sample of scan 3, then hold
        do_reset(K0);
        step_to(28); pressed = '0;
        step_to(32); pressed = K0;
        step_to(35); check("bounce.kb@35", 32'(keyboard), 32'd0);
        step_to(70); check("bounce.kb@70", 32'(keyboard), 32'd0);
        step_to(71); check("bounce.kb@71", 32'(keyboard), 32'b0000000001);
        check("bounce.strobe@71", 32'(key_strobe), 32'd1);

        // Multi-key from start is never accepted
        do_reset(K1 | K9);
        step_to(47); check_outs("multi@47", 10'd0, 1'b1, 1'b1);
        check("multi.strobes", 32'(strobe_cnt), 32'd0);

        // Accepted 1 released by three multi-key scans
        do_reset(K1);
        step_to(35); check("k1.kb@35", 32'(keyboard), 32'b0000000010);
        step_to(36); pressed = K1 | K9;
        step_to(70); check("k1.kb@70", 32'(keyboard), 32'b0000000010);
        step_to(71); check_outs("k1multi@71", 10'd0, 1'b1, 1'b1);
        step_to(72); check("k1multi.strobes", 32'(strobe_cnt), 32'd1);

        // Hold 7, asynchronous clear at column 1 dwell 2, re-accept
        do_reset(K7);
        step_to(35); check("k7.kb@35", 32'(keyboard), 32'b0010000000);
        step_to(41); #2 clear = 1'b1; #1;
        check("k7clr.col_n", 32'(col_n), 32'b110);
        check_outs("k7clr", 10'd0, 1'b1, 1'b1);
        check("k7clr.strobe", 32'(key_strobe), 32'd0);
        do_reset(K7);
        step_to(34); check("k7re.kb@34", 32'(keyboard), 32'd0);
        step_to(35); check("k7re.kb@35", 32'(keyboard), 32'b0010000000);
        check("k7re.strobe@35", 32'(key_strobe), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
